popcount_accumulator: RTL and testbench

//   Sequential, parametrised ones counter for WIDTH-bit words. Sums popcount(din)
//   (or zero-count) over a frame of FRAME_LEN words and presents the total with a

---
 rtl/popcount_accumulator.sv | 137 +++++++++++++
 tb/tb_popcount_accumulator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_accumulator.sv
// popcount_accumulator
// Sums the number of ones (or zeros) across a frame of FRAME_LEN words of
// WIDTH bits each, then offers the frame total to a consumer through a
// valid/ready handshake. The result register is sized so the largest possible
// total (every bit of every word counted) fits without wrapping.

module popcount_accumulator #(
   parameter  int WIDTH     = 3,
   parameter  int FRAME_LEN = 4,
   localparam int CNT_W     = $clog2(WIDTH * FRAME_LEN + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] din_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] count_o,
   output logic             parity_o,
   output logic             busy_o
);

   // Word counter only has to reach FRAME_LEN-1; keep it at least one bit wide
   // so a single-word frame still has a legal register.
   localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [WC_W-1:0]  LAST_WORD   = WC_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] WIDTH_CNT   = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [WC_W-1:0]  wordCnt_q, wordCnt_d;
   logic             mode_q, mode_d;

   logic             accept;
   logic             lastWord;
   logic [CNT_W-1:0] onesInWord;
   logic [CNT_W-1:0] wordContribution;

   // Number of set bits in one input word. A word can hold at most WIDTH ones,
   // which never exceeds the frame maximum, so CNT_W bits are always enough.
   function automatic logic [CNT_W-1:0] onesOf(input logic [WIDTH-1:0] word);
      logic [CNT_W-1:0] ones;
      ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + CNT_W'(word[i]);
      end
      return ones;
   endfunction

   // Handshake qualifiers and the per-word amount to add. Zero counting is the
   // complement of the ones count, using the mode latched at frame start so a
   // mid-frame change of mode_i cannot corrupt a running total.
   always_comb begin
      accept           = in_valid_i && (state_q == ACCUM);
      lastWord         = (wordCnt_q == LAST_WORD);
      onesInWord       = onesOf(din_i);
      wordContribution = mode_q ? (WIDTH_CNT - onesInWord) : onesInWord;
   end

   // Next-state and datapath update. Everything holds by default; each state
   // only overrides what it actually changes.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      wordCnt_d = wordCnt_q;
      mode_d    = mode_q;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = ACCUM;
               acc_d     = '0;
               wordCnt_d = '0;
               mode_d    = mode_i;
            end
         end

         ACCUM: begin
            if (accept) begin
               acc_d     = acc_q + wordContribution;
               wordCnt_d = wordCnt_q + WC_W'(1);
               if (lastWord) begin
                  state_d = HOLD;
               end
            end
         end

         HOLD: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset drops any partial frame on the floor,
   // so no stale total is ever presented after it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         wordCnt_q <= '0;
         mode_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         wordCnt_q <= wordCnt_d;
         mode_q    <= mode_d;
      end
   end

   // Outputs come straight from registers. The total stays visible after the
   // handshake until the next frame clears it, so consumers must qualify it
   // with out_valid_o.
   always_comb begin
      in_ready_o  = (state_q == ACCUM);
      out_valid_o = (state_q == HOLD);
      busy_o      = (state_q != IDLE);
      count_o     = acc_q;
      parity_o    = acc_q[0];
   end

endmodule

// File: tb/tb_popcount_accumulator.sv
// tb_popcount_accumulator
// Drives directed frames into two instances (3-bit words x4 and 8-bit words x1).
// Each frame pushes its hand-computed total into a scoreboard queue; monitor
// processes pop and compare whenever a DUT completes an output handshake.

module tb_popcount_accumulator;

   typedef struct {
      logic [3:0] cnt;
      logic       par;
      string      tag;
   } exp_t;

   logic       clk;
   logic       rst;

   logic       start, mode, inValid, inReady, outValid, outReady, parity, busy;
   logic [2:0] din;
   logic [3:0] count;

   logic       bStart, bMode, bInValid, bInReady, bOutValid, bOutReady, bParity, bBusy;
   logic [7:0] bDin;
   logic [3:0] bCount;

   exp_t       sbA[$];
   exp_t       sbB[$];

   int         checks   = 0;
   int         failures = 0;

   popcount_accumulator #(.WIDTH(3), .FRAME_LEN(4)) dutA (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .mode_i      (mode),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady),
      .din_i       (din),
      .out_valid_o (outValid),
      .out_ready_i (outReady),
      .count_o     (count),
      .parity_o    (parity),
      .busy_o      (busy)
   );

   popcount_accumulator #(.WIDTH(8), .FRAME_LEN(1)) dutB (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (bStart),
      .mode_i      (bMode),
      .in_valid_i  (bInValid),
      .in_ready_o  (bInReady),
      .din_i       (bDin),
      .out_valid_o (bOutValid),
      .out_ready_i (bOutReady),
      .count_o     (bCount),
      .parity_o    (bParity),
      .busy_o      (bBusy)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so the run always ends even if the design locks up.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Advance one cycle and settle just after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the 3-bit instance: compare every completed handshake.
   always @(negedge clk) begin
      if (!rst && outValid && outReady) begin
         exp_t e;
         if (sbA.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL A unexpected output: got count %0d expected none", count);
         end else begin
            e = sbA.pop_front();
            checkOutput({e.tag, " count"}, 32'(count), 32'(e.cnt));
            checkOutput({e.tag, " parity"}, 32'(parity), 32'(e.par));
         end
      end
   end

   // Monitor for the 8-bit single-word instance.
   always @(negedge clk) begin
      if (!rst && bOutValid && bOutReady) begin
         exp_t e;
         if (sbB.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL B unexpected output: got count %0d expected none", bCount);
         end else begin
            e = sbB.pop_front();
            checkOutput({e.tag, " count"}, 32'(bCount), 32'(e.cnt));
            checkOutput({e.tag, " parity"}, 32'(bParity), 32'(e.par));
         end
      end
   end

   // Run one frame on the 3-bit instance up to the point where out_valid
   // should rise. Mode is flipped right after start to show it is latched.
   task automatic applyStimulus(input string tag, input logic m,
                                input logic [2:0] words [4], input int gap,
                                input logic holdStart, input logic [3:0] expCnt,
                                input logic expPar);
      sbA.push_back('{expCnt, expPar, tag});
      start = 1'b1;
      mode  = m;
      tick();
      if (!holdStart) start = 1'b0;
      mode = ~m;
      checkOutput({tag, " in_ready in ACCUM"}, 32'(inReady), 32'd1);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap; g++) begin
            inValid = 1'b0;
            tick();
         end
         inValid = 1'b1;
         din     = words[i];
         tick();
      end
      inValid = 1'b0;
      checkOutput({tag, " out_valid after last word"}, 32'(outValid), 32'd1);
   endtask

   // Hold the result for a while with in_valid pulses, then complete the
   // handshake and confirm the block is back in IDLE.
   task automatic finishFrame(input string tag, input int holdCycles,
                              input logic [3:0] expCnt);
      outReady = 1'b0;
      for (int h = 0; h < holdCycles; h++) begin
         inValid = h[0];
         din     = 3'b111;
         checkOutput({tag, " hold out_valid"}, 32'(outValid), 32'd1);
         checkOutput({tag, " hold count"}, 32'(count), 32'(expCnt));
         checkOutput({tag, " hold in_ready"}, 32'(inReady), 32'd0);
         tick();
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput({tag, " busy after handshake"}, 32'(busy), 32'd0);
      checkOutput({tag, " out_valid after handshake"}, 32'(outValid), 32'd0);
   endtask

   logic [2:0] vecMixed [4];
   logic [2:0] vecOnes  [4];
   logic [2:0] vecLow   [4];

   initial begin
      vecMixed = '{3'b111, 3'b101, 3'b000, 3'b011};
      vecOnes  = '{3'b111, 3'b111, 3'b111, 3'b111};
      vecLow   = '{3'b001, 3'b001, 3'b001, 3'b001};

      rst = 1'b1;
      start = 1'b0; mode = 1'b0; inValid = 1'b0; din = '0; outReady = 1'b0;
      bStart = 1'b0; bMode = 1'b0; bInValid = 1'b0; bDin = '0; bOutReady = 1'b0;
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("reset in_ready", 32'(inReady), 32'd0);
      checkOutput("reset out_valid", 32'(outValid), 32'd0);
      checkOutput("reset count", 32'(count), 32'd0);
      checkOutput("reset parity", 32'(parity), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] ones count, back-to-back words");
      applyStimulus("t1 ones", 1'b0, vecMixed, 0, 1'b0, 4'd7, 1'b1);
      finishFrame("t1", 0, 4'd7);

      $display("[TB] zeros count and full-scale frame");
      applyStimulus("t2 zeros", 1'b1, vecMixed, 0, 1'b0, 4'd5, 1'b1);
      finishFrame("t2a", 0, 4'd5);
      applyStimulus("t2 all ones", 1'b0, vecOnes, 0, 1'b0, 4'd12, 1'b0);
      finishFrame("t2b", 0, 4'd12);

      $display("[TB] consumer stalls in HOLD");
      applyStimulus("t3 stall", 1'b0, vecMixed, 0, 1'b0, 4'd7, 1'b1);
      finishFrame("t3", 5, 4'd7);

      $display("[TB] input gaps");
      applyStimulus("t4 gaps", 1'b0, vecMixed, 2, 1'b0, 4'd7, 1'b1);
      finishFrame("t4", 0, 4'd7);

      $display("[TB] reset in the middle of a frame");
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      inValid = 1'b1; din = 3'b111;
      tick();
      din = 3'b011;
      tick();
      inValid = 1'b0;
      rst = 1'b1;
      tick();
      checkOutput("t5 in_ready after reset", 32'(inReady), 32'd0);
      checkOutput("t5 out_valid after reset", 32'(outValid), 32'd0);
      checkOutput("t5 count after reset", 32'(count), 32'd0);
      checkOutput("t5 parity after reset", 32'(parity), 32'd0);
      checkOutput("t5 busy after reset", 32'(busy), 32'd0);
      rst = 1'b0;
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t5 no out_valid after reset", 32'(outValid), 32'd0);
      end
      outReady = 1'b0;
      applyStimulus("t5 new frame", 1'b0, vecLow, 0, 1'b0, 4'd4, 1'b0);
      finishFrame("t5", 0, 4'd4);

      $display("[TB] start held through the handshake");
      applyStimulus("t6 start held", 1'b0, vecMixed, 0, 1'b1, 4'd7, 1'b1);
      finishFrame("t6", 0, 4'd7);
      start = 1'b0;
      tick();
      checkOutput("t6 still idle", 32'(busy), 32'd0);
      checkOutput("t6 in_ready idle", 32'(inReady), 32'd0);
      checkOutput("t6 total retained", 32'(count), 32'd7);

      $display("[TB] single-word frames on the 8-bit instance");
      sbB.push_back('{4'd8, 1'b0, "t6 B FF"});
      bStart = 1'b1; bMode = 1'b0;
      tick();
      bStart = 1'b0;
      checkOutput("t6 B in_ready", 32'(bInReady), 32'd1);
      bInValid = 1'b1; bDin = 8'hFF;
      tick();
      bInValid = 1'b0;
      checkOutput("t6 B out_valid", 32'(bOutValid), 32'd1);
      bOutReady = 1'b1;
      tick();
      bOutReady = 1'b0;
      checkOutput("t6 B busy after", 32'(bBusy), 32'd0);

      sbB.push_back('{4'd4, 1'b0, "t6 B zeros 0F"});
      bStart = 1'b1; bMode = 1'b1;
      tick();
      bStart = 1'b0; bMode = 1'b0;
      bInValid = 1'b1; bDin = 8'h0F;
      tick();
      bInValid = 1'b0;
      bOutReady = 1'b1;
      tick();
      bOutReady = 1'b0;

      sbB.push_back('{4'd1, 1'b1, "t6 B 01"});
      bStart = 1'b1; bMode = 1'b0;
      tick();
      bStart = 1'b0;
      bInValid = 1'b1; bDin = 8'h01;
      tick();
      bInValid = 1'b0;
      bOutReady = 1'b1;
      tick();
      bOutReady = 1'b0;
      tick();

      checkOutput("scoreboard A drained", 32'(sbA.size()), 32'd0);
      checkOutput("scoreboard B drained", 32'(sbB.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
